// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per step, MSB first.
module muldiv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    if (init_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply-divide unit: FSM, combinational multiplier retimed by a counter,
// iterative divider and the final sign/special-case fixup.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int EARLY_OUT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            spec_q, spec_d;
  logic [XLEN-1:0] result_q, result_d;

  logic              accept, special_in;
  logic [XLEN-1:0]   dividend_mag, divisor_mag, quo, rem;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0]   mul_res, div_res;
  logic              sgn, q_neg, r_neg;

  assign accept     = start_i && (state_q == IDLE) && !flush_i;
  assign special_in = is_div(op_i) &&
                      ((b_i == '0) || (is_signed_a(op_i) && (a_i == MIN_INT) && (&b_i)));
  assign dividend_mag = (is_signed_a(op_i) && a_i[XLEN-1]) ? -a_i : a_i;
  assign divisor_mag  = (is_signed_b(op_i) && b_i[XLEN-1]) ? -b_i : b_i;

  muldiv_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_i     (accept),
    .step_i     (state_q == DIV),
    .dividend_i (dividend_mag),
    .divisor_i  (divisor_mag),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // Operands are extended to 2*XLEN, so the wrapped product is exact for all sign mixes.
  always_comb begin
    ext_a   = is_signed_a(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    ext_b   = is_signed_b(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    sgn   = is_signed_a(op_q);
    q_neg = sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg = sgn && a_q[XLEN-1];
    if (spec_q) begin
      if (b_q == '0) div_res = op_q[1] ? a_q : '1;
      else           div_res = op_q[1] ? '0 : MIN_INT;
    end else if (op_q[1]) begin
      div_res = r_neg ? -rem : rem;
    end else begin
      div_res = q_neg ? -quo : quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (!op_i[2])                          state_d = MUL;
        else if ((EARLY_OUT != 0) && special_in) state_d = FIX;
        else                                   state_d = DIV;
      end
      MUL:  if (cnt_q == MUL_LAST) state_d = DONE;
      DIV:  if (cnt_q == DIV_LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Captured operands and the shared MUL/DIV cycle counter.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    spec_d = spec_q;
    if (accept) begin
      cnt_d  = '0;
      op_d   = op_i;
      a_d    = a_i;
      b_d    = b_i;
      spec_d = special_in;
    end else if ((state_q == MUL) || (state_q == DIV)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    result_d = result_q;
    if (!flush_i && (state_d == DONE)) begin
      result_d = (state_q == MUL) ? mul_res : div_res;
    end
    busy_o   = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    valid_o  = (state_q == DONE);
    result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): vector table plus flush, held-start and reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_CYCLES(2), .EARLY_OUT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, return result and latency in cycles counted from the start cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    lat = 0;
    busy1 = 1'b0;
    res = 'x;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start_i = 1'b0;
        busy1 = busy_o;
      end
      if (valid_o) begin
        res = result_o;
        break;
      end
    end
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] res, prior;
    logic        busy1;
    int          lat, nval;

    vecs[0]  = '{"mul_7_m3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 3};
    vecs[1]  = '{"mulh_min_min",  3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 3};
    vecs[2]  = '{"mulhsu_m1_max", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 3};
    vecs[3]  = '{"mulhu_max_max", 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 3};
    vecs[4]  = '{"mul_lo",        3'b000, 32'h12345678,   32'h00000010, 32'h23456780, 3};
    vecs[5]  = '{"mulhu_small",   3'b011, 32'h12345678,   32'h00000010, 32'h00000001, 3};
    vecs[6]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
    vecs[7]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,        32'd14,       34};
    vecs[9]  = '{"remu_100_7",    3'b111, 32'd100,        32'd7,        32'd2,        34};
    vecs[10] = '{"div_7_m2",      3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[11] = '{"rem_7_m2",      3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        34};
    vecs[12] = '{"div_5_0",       3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 2};
    vecs[13] = '{"rem_5_0",       3'b110, 32'd5,          32'd0,        32'd5,        2};
    vecs[14] = '{"div_ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2};
    vecs[15] = '{"rem_ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 2};

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy1);
      $display("vec %0d %s: result=0x%08h latency=%0d", i, vecs[i].name, res, lat);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_busy"}, {31'd0, busy1}, 32'd1);
      @(posedge clk); #1;
      chk({vecs[i].name, "_pulse"}, {31'd0, valid_o}, 32'd0);
    end

    // Flush 10 cycles into a divide.
    prior = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    nval = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    $display("flush: valid pulses=%0d result=0x%08h", nval, result_o);
    chk("flush_no_valid", nval, 0);
    chk("flush_result_kept", result_o, prior);

    run_op(3'b000, 32'd3, 32'd4, res, lat, busy1);
    $display("mul_after_flush: result=0x%08h latency=%0d", res, lat);
    chk("mul_after_flush", res, 32'd12);
    @(posedge clk); #1;

    // Flush together with start in IDLE drops the start.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; a_i = 32'd5; b_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    $display("flush_with_start: busy=%0b", busy_o);
    chk("flush_start_dropped", {31'd0, busy_o}, 32'd0);
    chk("flush_start_result", result_o, 32'd12);

    // Start held high for 40 cycles: one completion, then a re-accept in flight.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
    nval = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    start_i = 1'b0;
    $display("held_start: valid pulses=%0d busy=%0b result=0x%08h", nval, busy_o, result_o);
    chk("held_one_valid", nval, 1);
    chk("held_result", result_o, 32'd14);
    chk("held_busy_reissue", {31'd0, busy_o}, 32'd1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async_reset: busy=%0b valid=%0b result=0x%08h", busy_o, valid_o, result_o);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    nval = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    chk("rst_no_valid", nval, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
